// File: rtl/trace_overlay.sv
// Overlays a scrolling 8-bit sample trace onto a 24-bit RGB video stream, 2-clock latency.
// Define TRACE_OVERLAY_GRID_EN to also paint the plot midline in GRID_COLOR.
module trace_overlay #(
    parameter int          HACTIVE     = 1280,
    parameter int          DEPTH       = 256,
    parameter int          Y_TOP       = 100,
    parameter logic [23:0] TRACE_COLOR = 24'hff0000,
    parameter logic [23:0] GRID_COLOR  = 24'h808080
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] in_data,
    input  logic        in_de,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic [7:0]  sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [23:0] video_data,
    output logic        video_de,
    output logic        video_hsync,
    output logic        video_vsync
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int XW = $clog2(HACTIVE) + 2;
    localparam int YW = 16;

    typedef enum logic [1:0] {SYNC, BLANK, ACTIVE} state_t;
    state_t state, state_nxt;
    logic   start_frame;

    logic [7:0]    fifo_mem [4];
    logic [1:0]    fifo_rd, fifo_wr;
    logic [2:0]    fifo_cnt;
    logic          push, pop;

    logic [7:0]    ram [DEPTH];
    logic [AW-1:0] wr_ptr, base, base_nxt, rd_addr;
    logic [FW-1:0] fill, fill_latched;

    logic          de_d, vs_d, de_rise, vs_rise;
    logic [XW-1:0] x_cnt, x_pix;
    logic [YW-1:0] y_line, y_next, y_pix;

    logic [23:0]   data_p0;
    logic          vld_p0, hs_p0, vs_p0;
    logic [XW-1:0] x_p0;
    logic [YW-1:0] y_p0;
    logic [7:0]    ram_q_p0;
    logic [YW-1:0] trace_line;
    logic          trace_hit, grid_hit;

    function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
        return (v == FW'(DEPTH)) ? v : v + 1'b1;
    endfunction

    assign vs_rise = in_vsync && !vs_d;
    assign de_rise = in_de && !de_d;
    assign x_pix   = de_rise ? '0 : x_cnt;
    assign y_pix   = de_rise ? y_next : y_line;

    assign sample_ready = reset_n && (fifo_cnt != 3'd4);
    assign push         = sample_valid && sample_ready;
    // The line-start cycle is left out of the drain so RAM is frozen from the first visible pixel.
    assign pop          = (state == BLANK) && !in_de && (fifo_cnt != 3'd0);

    // The first pixel of a frame is read in the same clock that latches base, so bypass it.
    assign base_nxt = start_frame ? ((fill == FW'(DEPTH)) ? wr_ptr : '0) : base;
    assign rd_addr  = base_nxt + x_pix[AW-1:0];

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        case (state)
            SYNC:   if (vs_rise) state_nxt = BLANK;
            BLANK:  if (in_de) begin
                        state_nxt   = ACTIVE;
                        start_frame = 1'b1;
                    end
            ACTIVE: if (vs_rise) state_nxt = BLANK;
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= SYNC;
            fifo_rd      <= '0;
            fifo_wr      <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            fill         <= '0;
            base         <= '0;
            fill_latched <= '0;
            de_d         <= 1'b0;
            vs_d         <= 1'b0;
            x_cnt        <= '0;
            y_line       <= '0;
            y_next       <= '0;
        end else begin
            state    <= state_nxt;
            de_d     <= in_de;
            vs_d     <= in_vsync;
            fifo_cnt <= fifo_cnt + {2'b0, push} - {2'b0, pop};
            if (push) fifo_wr <= fifo_wr + 1'b1;
            if (pop) begin
                fifo_rd <= fifo_rd + 1'b1;
                wr_ptr  <= wr_ptr + 1'b1;
                fill    <= sat_inc(fill);
            end
            if (start_frame) begin
                base         <= base_nxt;
                fill_latched <= fill;
            end
            if (in_de) x_cnt <= x_pix + 1'b1;
            if (vs_rise) begin
                y_next <= '0;
            end else if (de_rise) begin
                y_line <= y_next;
                y_next <= y_next + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[fifo_wr] <= sample_data;
        if (pop) ram[wr_ptr] <= fifo_mem[fifo_rd];
        ram_q_p0 <= ram[rd_addr];
    end

    // Stage p0: register the incoming pixel, its coordinates and the RAM sample for column x.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
            hs_p0   <= 1'b0;
            vs_p0   <= 1'b0;
            x_p0    <= '0;
            y_p0    <= '0;
        end else begin
            data_p0 <= in_data;
            vld_p0  <= in_de;
            hs_p0   <= in_hsync;
            vs_p0   <= in_vsync;
            x_p0    <= x_pix;
            y_p0    <= y_pix;
        end
    end

    assign trace_line = YW'(Y_TOP + 255) - {8'b0, ram_q_p0};
    assign trace_hit  = vld_p0 && (32'(x_p0) < 32'(fill_latched)) && (y_p0 == trace_line);
`ifdef TRACE_OVERLAY_GRID_EN
    assign grid_hit   = vld_p0 && (y_p0 == YW'(Y_TOP + 128));
`else
    assign grid_hit   = 1'b0;
`endif

    // Stage p1: colour substitution into the output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            video_data  <= '0;
            video_de    <= 1'b0;
            video_hsync <= 1'b0;
            video_vsync <= 1'b0;
        end else begin
            video_data  <= trace_hit ? TRACE_COLOR : (grid_hit ? GRID_COLOR : data_p0);
            video_de    <= vld_p0;
            video_hsync <= hs_p0;
            video_vsync <= vs_p0;
        end
    end
endmodule

// File: tb/tb_trace_overlay.sv
// Self-checking bench for trace_overlay: directed frame scenarios with random pixels/samples
// compared every clock against a queue-based reference model.
module tb_trace_overlay;
    localparam int          HACTIVE     = 20;
    localparam int          DEPTH       = 16;
    localparam int          Y_TOP       = 4;
    localparam logic [23:0] TRACE_COLOR = 24'hff0000;
    localparam logic [23:0] GRID_COLOR  = 24'h808080;
    localparam int          NLINES      = Y_TOP + 256;
    localparam int          HBLANK      = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [23:0] in_data;
    logic        in_de, in_hsync, in_vsync;
    logic [7:0]  sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [23:0] video_data;
    logic        video_de, video_hsync, video_vsync;

    always #5 clock = ~clock;

    trace_overlay #(
        .HACTIVE(HACTIVE), .DEPTH(DEPTH), .Y_TOP(Y_TOP),
        .TRACE_COLOR(TRACE_COLOR), .GRID_COLOR(GRID_COLOR)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_data(in_data), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .video_data(video_data), .video_de(video_de),
        .video_hsync(video_hsync), .video_vsync(video_vsync)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pending skid samples, committed history, and the snapshot shown this frame.
    int          pend[$];
    int          hist[$];
    int          shown[$];
    int          phase;          // 0 sync, 1 blank, 2 active
    int          lines, cx, cy;
    logic        m_de_d, m_vs_d;
    logic [26:0] exp_d1, exp_d2;
    logic [23:0] px;
    bit          m_push;
    int          acc_cnt;

    logic [7:0]  offer[$];

    logic [23:0] cap  [NLINES][HACTIVE];
    logic [23:0] icap [NLINES][HACTIVE];
    int          ox, oy, olines, trace_cnt;
    logic        o_de_d = 1'b0, o_vs_d = 1'b0;

    always @(posedge clock) begin
        m_push = 1'b0;
        if (sample_valid && sample_ready) acc_cnt++;
        if (!reset_n) begin
            pend.delete(); hist.delete(); shown.delete();
            phase = 0; lines = 0; cx = 0; cy = 0; m_de_d = 1'b0; m_vs_d = 1'b0;
            exp_d1 = '0; exp_d2 = '0;
        end else begin
            m_push = sample_valid && (pend.size() < 4);
            if (phase == 1 && !in_de && pend.size() > 0) begin
                hist.push_back(pend.pop_front());
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            if (m_push) pend.push_back(int'(sample_data));
            if (phase == 1 && in_de) begin
                shown = hist;
                phase = 2;
            end
            if (in_vsync && !m_vs_d) begin
                phase = 1;
                lines = 0;
            end
            if (in_de) begin
                if (!m_de_d) begin
                    cy = lines; lines++; cx = 0;
                end else cx++;
            end
            px = in_data;
            if (in_de) begin
                if (cx < shown.size() && cy == Y_TOP + 255 - shown[cx]) px = TRACE_COLOR;
`ifdef TRACE_OVERLAY_GRID_EN
                else if (cy == Y_TOP + 128) px = GRID_COLOR;
`endif
            end
            exp_d2 = exp_d1;
            exp_d1 = {px, in_de, in_hsync, in_vsync};
            m_de_d = in_de;
            m_vs_d = in_vsync;
        end
    end

    always @(posedge clock) begin
        #1;
        checks++;
        assert ({video_data, video_de, video_hsync, video_vsync} === exp_d2) else begin
            errors++;
            $error("FAIL video: got %h expected %h at %0t",
                   {video_data, video_de, video_hsync, video_vsync}, exp_d2, $time);
        end
        checks++;
        assert (sample_ready === (reset_n && pend.size() < 4)) else begin
            errors++;
            $error("FAIL sample_ready: got %b expected %b at %0t",
                   sample_ready, (reset_n && pend.size() < 4), $time);
        end
        if (video_vsync && !o_vs_d) begin
            olines = 0; trace_cnt = 0;
        end
        if (video_de) begin
            if (!o_de_d) begin
                oy = olines; olines++; ox = 0;
            end else ox++;
            if (oy < NLINES && ox < HACTIVE) cap[oy][ox] = video_data;
            if (video_data === TRACE_COLOR) trace_cnt++;
        end
        o_de_d = video_de;
        o_vs_d = video_vsync;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rnd_px();
        return 24'($urandom) & 24'h7fffff;
    endfunction

    task automatic step();
        sample_valid = (offer.size() > 0);
        sample_data  = (offer.size() > 0) ? offer[0] : 8'h00;
        @(negedge clock);
        if (m_push) void'(offer.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_data = rnd_px();
            step();
        end
    endtask

    task automatic frame(input int vblank, input int burst_line, input int burst_n,
                         input int rst_line);
        in_de = 1'b0; in_hsync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_vsync = 1'b1; in_data = rnd_px(); step();
        end
        in_vsync = 1'b0;
        for (int i = 0; i < vblank; i++) begin
            in_data = rnd_px(); step();
        end
        for (int y = 0; y < NLINES; y++) begin
            for (int x = 0; x < HACTIVE; x++) begin
                if (y == burst_line && x == 0) begin
                    acc_cnt = 0;
                    for (int k = 0; k < burst_n; k++) offer.push_back(8'($urandom));
                end
                if (y == burst_line && x == 4 && burst_n == 6)
                    chk("ready_low_5th", 32'(sample_ready), 32'(0));
                if (y == burst_line && x == 6) offer.delete();
                if (y == rst_line && x == 5) reset_n = 1'b0;
                if (y == rst_line && x == 8) reset_n = 1'b1;
                in_de = 1'b1; in_data = rnd_px(); icap[y][x] = in_data;
                step();
            end
            in_de = 1'b0;
            for (int i = 0; i < HBLANK; i++) begin
                in_hsync = (i < 2); in_data = rnd_px(); step();
            end
            in_hsync = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            in_data = rnd_px(); step();
        end
    endtask

    initial begin
        reset_n = 1'b0; in_data = 24'h123456; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        sample_valid = 1'b0; sample_data = 8'h00; acc_cnt = 0;
        ox = 0; oy = 0; olines = 0; trace_cnt = 0;
        @(negedge clock);

        // Reset behaviour
        for (int i = 0; i < 5; i++) step();
        chk("rst_video_data", 32'(video_data), 32'(0));
        chk("rst_video_ctl", 32'({video_de, video_hsync, video_vsync}), 32'(0));
        chk("rst_sample_ready", 32'(sample_ready), 32'(0));
        reset_n = 1'b1;
        step(); step();
        chk("release_passthru", 32'(video_data), 32'h123456);

        // Samples 0, 255, 128 before the first vsync, then two frames
        offer.push_back(8'd0); offer.push_back(8'd255); offer.push_back(8'd128);
        idle(6);
        frame(10, -1, 0, -1);
        frame(10, -1, 0, -1);
        chk("trace_v0_x0", 32'(cap[Y_TOP + 255][0]), 32'(TRACE_COLOR));
        chk("trace_v255_x1", 32'(cap[Y_TOP][1]), 32'(TRACE_COLOR));
        chk("trace_v128_x2", 32'(cap[Y_TOP + 127][2]), 32'(TRACE_COLOR));
        chk("trace_count3", 32'(trace_cnt), 32'(3));
        chk("pass_x5", 32'(cap[Y_TOP + 200][5]), 32'(icap[Y_TOP + 200][5]));

        // Six back-to-back offers during ACTIVE
        frame(10, 10, 6, -1);
        chk("burst_accepted", 32'(acc_cnt), 32'(4));
        chk("ready_low_till_blank", 32'(sample_ready), 32'(0));
        frame(10, -1, 0, -1);
        chk("after_drain_ready", 32'(sample_ready), 32'(1));

        // DEPTH+1 samples: fill saturates and the oldest sample is dropped
        reset_n = 1'b0; idle(3); reset_n = 1'b1;
        for (int i = 0; i <= DEPTH; i++) offer.push_back(8'(i % 256));
        frame(40, -1, 0, -1);
        chk("wrap_x0_val1", 32'(cap[Y_TOP + 255 - 1][0]), 32'(TRACE_COLOR));
        chk("wrap_xlast", 32'(cap[Y_TOP + 255 - (DEPTH % 256)][DEPTH - 1]), 32'(TRACE_COLOR));
        chk("wrap_count", 32'(trace_cnt), 32'(DEPTH));

        // Reset mid-ACTIVE with 3 samples buffered
        frame(10, 10, 3, 20);
        frame(10, -1, 0, -1);
        chk("post_reset_no_trace", 32'(trace_cnt), 32'(0));
`ifdef TRACE_OVERLAY_GRID_EN
        chk("grid_x0", 32'(cap[Y_TOP + 128][0]), 32'(GRID_COLOR));
        chk("grid_xlast", 32'(cap[Y_TOP + 128][HACTIVE - 1]), 32'(GRID_COLOR));
`else
        chk("nogrid_x0", 32'(cap[Y_TOP + 128][0]), 32'(icap[Y_TOP + 128][0]));
        chk("nogrid_xlast", 32'(cap[Y_TOP + 128][HACTIVE - 1]),
            32'(icap[Y_TOP + 128][HACTIVE - 1]));
`endif

        // Random samples in blanking and mid-frame bursts
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < int'($urandom_range(12, 1)); k++) offer.push_back(8'($urandom));
            frame(30, int'($urandom_range(200, 5)), int'($urandom_range(6, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trace_overlay.md
TRACE_OVERLAY -- requirements
Module: trace_overlay

Interface
REQ-001 SHALL have parameter HACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter DEPTH, default 256, trace sample buffer depth (power of two, at most HACTIVE).
REQ-003 SHALL have parameter Y_TOP, default 100, first active line of the 256-line plot area.
REQ-004 SHALL have parameter TRACE_COLOR, default 24'hff0000, RGB drawn at trace pixels.
REQ-005 SHALL have parameter GRID_COLOR, default 24'h808080, RGB for the midline (see Configuration).
REQ-006 clock  input  1  sole clock; all logic on rising edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 in_data  input  24  upstream RGB pixel.
REQ-009 in_de  input  1  upstream data enable.
REQ-010 in_hsync  input  1  upstream hsync, active high.
REQ-011 in_vsync  input  1  upstream vsync, active high.
REQ-012 sample_data  input  8  trace sample, 0 = bottom of plot.
REQ-013 sample_valid  input  1  sample offered.
REQ-014 sample_ready  output  1  high when the skid FIFO is not full.
REQ-015 video_data, video_de, video_hsync, video_vsync  output  24/1/1/1  overlaid stream.

Function
REQ-016 Video outputs SHALL equal the inputs delayed exactly 2 clocks, except that video_data is replaced as in REQ-021/REQ-027.
REQ-017 A sample SHALL transfer on any clock with sample_valid and sample_ready both high, into a 4-entry FIFO.
REQ-018 Frame FSM states: SYNC, BLANK, ACTIVE. SYNC->BLANK on in_vsync rising edge; BLANK->ACTIVE on the first in_de high; ACTIVE->BLANK on in_vsync rising edge.
REQ-019 In BLANK only, the FIFO SHALL pop one entry per clock when not empty, write it to RAM[wr_ptr], and increment wr_ptr modulo DEPTH; fill SHALL increment, saturating at DEPTH.
REQ-020 On the BLANK->ACTIVE transition, base SHALL latch wr_ptr if fill == DEPTH, otherwise 0; fill_latched SHALL latch fill.
REQ-021 Pixel x (0-based, in_de high count since in_de rising) on active line y (0-based, count of in_de rising edges since in_vsync rising) SHALL output TRACE_COLOR when x < fill_latched and y == Y_TOP + 255 - RAM[(base + x) mod DEPTH].
REQ-022 All other pixels SHALL pass in_data unchanged; pixels with in_de low SHALL always pass.
REQ-023 Simultaneous push and pop SHALL leave the FIFO count unchanged; a pop from empty or a push when full SHALL never occur.
REQ-024 Samples arriving in SYNC or ACTIVE SHALL stay in the FIFO; sample_ready SHALL drop while the FIFO holds 4 entries.
REQ-025 A sample written to RAM during BLANK SHALL first appear in the following ACTIVE frame; RAM SHALL not change during ACTIVE.

Reset
REQ-026 While reset_n is low: all video outputs 0, sample_ready 0, FIFO empty, wr_ptr/fill/base/fill_latched/x/y 0, FSM to SYNC; RAM contents are not cleared but never drawn while fill is 0. Reset asserted mid-frame SHALL discard buffered samples and resume in SYNC.

Configuration
REQ-027 With macro TRACE_OVERLAY_GRID_EN defined, an active pixel on line y == Y_TOP + 128 that is not a trace pixel SHALL output GRID_COLOR; without it no grid logic is built and such pixels pass in_data.

Verification
REQ-028 Reset: hold reset_n low for 5 clocks with in_data=24'h123456 -> all video outputs 0 and sample_ready 0; on release, in_data appears unchanged at video_data 2 clocks later.
REQ-029 Push samples 0, 255, 128 before the first vsync; run two frames -> frame 2 line Y_TOP+255 x=0, line Y_TOP x=1, and line Y_TOP+127 x=2 are all TRACE_COLOR; all pixels with x >= 3 pass.
REQ-030 Offer 6 samples back-to-back during ACTIVE -> exactly 4 accepted, sample_ready low from the 5th cycle onward until BLANK; the first 4 drain in 4 BLANK clocks.
REQ-031 Write DEPTH+1 samples with values equal to index mod 256 -> fill saturates at DEPTH; base = 1; x=0 shows sample value 1 and x=DEPTH-1 shows value DEPTH mod 256.
REQ-032 Assert reset_n low mid-ACTIVE with 3 samples in the FIFO -> FIFO empty, no trace drawn in the next frame.
REQ-033 With TRACE_OVERLAY_GRID_EN defined and fill 0 -> line Y_TOP+128 outputs GRID_COLOR for all active pixels; without the macro -> it outputs in_data.
